// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared constants and helpers for the hex debug display
package hex_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, bit0 = segment a ... bit6 = segment g
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic int num_pages(input int data_w, input int digits);
        return ((data_w / 4) + digits - 1) / digits;
    endfunction

endpackage

// File: rtl/hex_digit_decode.sv
// rtl/hex_digit_decode.sv - one seven-segment digit: nibble plus blank flag to active-low pattern
module hex_digit_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : hex_to_seg(nibble);
    end

endmodule

// File: rtl/hex_debug_display.sv
// rtl/hex_debug_display.sv - multi-channel paged hex debug display with freeze and leading-zero blanking
module hex_debug_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int DIGITS     = 6,
    parameter int PAGE_TICKS = 25_000_000,
    localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int NUM_PAGES = num_pages(DATA_W, DIGITS),
    localparam int PG_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic                     freeze,
    input  logic                     page_btn,
    input  logic                     auto_page,
    input  logic                     blank_lz,
    output logic [DIGITS*7-1:0]      hex_seg,
    output logic [PG_W-1:0]          page_idx,
    output logic                     frozen
);

    localparam int NIB   = DATA_W / 4;
    localparam int TMR_W = $clog2(PAGE_TICKS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PAGE_TICKS - 1);
    localparam logic [PG_W-1:0]  PG_LAST  = PG_W'(NUM_PAGES - 1);

    logic [DATA_W-1:0]   val_q, val_d, sel_data;
    logic [PG_W-1:0]     page_q, page_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [SEL_W-1:0]    sel_prev_q, sel_prev_d;
    logic                frozen_q, frozen_d;
    logic [DIGITS*7-1:0] seg_q, seg_d;
    logic                sel_chg, tick;

    logic [3:0]          dig_nib   [DIGITS];
    logic                dig_blank [DIGITS];
    logic [DATA_W-1:0]   shifted;
    int                  top, n;

    // Out-of-range selects fall through with sel_data left at zero
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == SEL_W'(k)) sel_data = ch_data[k*DATA_W +: DATA_W];
        end
        val_d      = freeze ? val_q : sel_data;
        frozen_d   = freeze;
        sel_prev_d = ch_sel;
    end

    // A channel change outranks both the button and the timer tick
    always_comb begin
        sel_chg = (ch_sel != sel_prev_q);
        tick    = auto_page && (tmr_q == TMR_LAST);
        tmr_d   = tmr_q + TMR_W'(1);
        if (!auto_page || sel_chg || page_btn || tick) tmr_d = '0;
        page_d = page_q;
        if (sel_chg) begin
            page_d = '0;
        end else if (page_btn || tick) begin
            page_d = (page_q == PG_LAST) ? '0 : page_q + PG_W'(1);
        end
    end

    always_comb begin
        top     = 0;
        n       = 0;
        shifted = '0;
        for (int i = 0; i < NIB; i++) begin
            if (val_q[i*4 +: 4] != 4'h0) top = i;
        end
        for (int d = 0; d < DIGITS; d++) begin
            n            = int'(page_q) * DIGITS + d;
            shifted      = val_q >> (4 * n);
            dig_nib[d]   = shifted[3:0];
            dig_blank[d] = (n >= NIB) || (blank_lz && (n > top) && (n != 0));
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        hex_digit_decode u_dec (
            .nibble (dig_nib[g]),
            .blank  (dig_blank[g]),
            .seg    (seg_d[g*7 +: 7])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q      <= '0;
            page_q     <= '0;
            tmr_q      <= '0;
            sel_prev_q <= '0;
            frozen_q   <= 1'b0;
            seg_q      <= {DIGITS{SEG_BLANK}};
        end else begin
            val_q      <= val_d;
            page_q     <= page_d;
            tmr_q      <= tmr_d;
            sel_prev_q <= sel_prev_d;
            frozen_q   <= frozen_d;
            seg_q      <= seg_d;
        end
    end

    assign hex_seg  = seg_q;
    assign page_idx = page_q;
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_hex_debug_display.sv
// tb/tb_hex_debug_display.sv - self-checking bench for hex_debug_display
module tb_hex_debug_display;

    localparam int NUM_CH     = 3;
    localparam int DATA_W     = 32;
    localparam int DIGITS     = 6;
    localparam int PAGE_TICKS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] ch_data;
    logic [1:0]  ch_sel;
    logic        freeze, page_btn, auto_page, blank_lz;
    logic [41:0] hex_seg;
    logic        page_idx;
    logic        frozen;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        blz;
        logic [41:0] exp;
    } vec_t;

    vec_t vt[9];

    hex_debug_display #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .DIGITS     (DIGITS),
        .PAGE_TICKS (PAGE_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_data   (ch_data),
        .ch_sel    (ch_sel),
        .freeze    (freeze),
        .page_btn  (page_btn),
        .auto_page (auto_page),
        .blank_lz  (blank_lz),
        .hex_seg   (hex_seg),
        .page_idx  (page_idx),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [41:0] model(input logic [31:0] v, input int pg, input bit blz);
        logic [41:0] r;
        int t;
        r = '0;
        t = 0;
        for (int i = 0; i < 8; i++) if (v[i*4 +: 4] != 4'h0) t = i;
        for (int d = 0; d < 6; d++) begin
            int nn;
            nn = pg * 6 + d;
            if (nn >= 8 || (blz && nn > t && nn != 0)) r[d*7 +: 7] = 7'h7F;
            else r[d*7 +: 7] = enc(v[nn*4 +: 4]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        ch_data[k*32 +: 32] = v;
    endtask

    logic [31:0] cur, frz_val, rel_val;
    string exp_pg;

    initial begin
        rst = 1'b1; ch_data = '0; ch_sel = '0; freeze = 1'b0;
        page_btn = 1'b0; auto_page = 1'b0; blank_lz = 1'b0;

        vt[0] = '{2'd0, 32'h0000_0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}};
        vt[1] = '{2'd2, 32'h89AB_CDEF, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        vt[2] = '{2'd1, 32'h0000_0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vt[3] = '{2'd1, 32'h0000_0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vt[4] = '{2'd0, 32'h0001_2000, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h40, 7'h40, 7'h40}};
        vt[5] = '{2'd2, 32'h0012_3456, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vt[6] = '{2'd0, 32'h7700_0000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vt[7] = '{2'd1, 32'h0000_789A, 1'b0, {7'h40, 7'h40, 7'h78, 7'h00, 7'h10, 7'h08}};
        vt[8] = '{2'd2, 32'h00DC_0B00, 1'b1, {7'h21, 7'h46, 7'h40, 7'h03, 7'h40, 7'h40}};

        repeat (2) cyc();
        chk("reset_seg", hex_seg, {6{7'h7F}});
        chk("reset_page", page_idx, 1'b0);
        chk("reset_frozen", frozen, 1'b0);

        rst = 1'b0;
        set_ch(0, 32'h0000_0001); blank_lz = 1'b1; ch_sel = 2'd0;
        cyc();
        chk("latency_1", hex_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        cyc();
        chk("latency_2", hex_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79});

        ch_data = {32'h5555_1234, 32'hA5A5_0F0F, 32'h0BAD_F00D};
        for (int i = 0; i < 9; i++) begin
            set_ch(int'(vt[i].sel), vt[i].data);
            ch_sel   = vt[i].sel;
            blank_lz = vt[i].blz;
            repeat (3) cyc();
            chk($sformatf("vec%0d_seg", i), hex_seg, vt[i].exp);
            chk($sformatf("vec%0d_page", i), page_idx, 1'b0);
        end

        ch_sel = 2'd2; set_ch(2, 32'h89AB_CDEF); blank_lz = 1'b0;
        repeat (3) cyc();
        page_btn = 1'b1;
        cyc();
        page_btn = 1'b0;
        chk("btn1_page", page_idx, 1'b1);
        chk("btn1_seg_old", hex_seg, {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        cyc();
        chk("btn1_seg_new", hex_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h10});
        set_ch(2, 32'h0123_4567); blank_lz = 1'b1;
        repeat (2) cyc();
        chk("page1_lz", hex_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79});
        blank_lz = 1'b0; page_btn = 1'b1;
        cyc();
        page_btn = 1'b0;
        chk("btn2_wrap", page_idx, 1'b0);
        cyc();
        chk("btn2_seg", hex_seg, {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78});

        ch_sel = 2'd1; cur = 32'h100; set_ch(1, cur);
        repeat (4) begin cyc(); cur = cur + 1; set_ch(1, cur); end
        freeze  = 1'b1;
        frz_val = cur - 1;
        repeat (2) begin cyc(); cur = cur + 1; set_ch(1, cur); end
        chk("frozen_flag", frozen, 1'b1);
        chk("freeze_hold_a", hex_seg, model(frz_val, 0, 1'b0));
        repeat (3) begin cyc(); cur = cur + 1; set_ch(1, cur); end
        chk("freeze_hold_b", hex_seg, model(frz_val, 0, 1'b0));
        freeze  = 1'b0;
        rel_val = cur;
        repeat (2) begin cyc(); cur = cur + 1; set_ch(1, cur); end
        chk("unfreeze_seg", hex_seg, model(rel_val, 0, 1'b0));
        chk("unfreeze_flag", frozen, 1'b0);

        exp_pg = {"0000", "1111", "0000", "1111", "0000", "1111", "00000000", "11", "0000", "1"};
        auto_page = 1'b1;
        for (int i = 1; i <= 38; i++) begin
            cyc();
            chk($sformatf("auto_page_e%0d", i), page_idx, (exp_pg[i] == "1"));
            if (i == 15 || i == 33) page_btn = 1'b1;
            else if (i == 27) begin ch_sel = 2'd2; page_btn = 1'b1; end
            else page_btn = 1'b0;
        end
        auto_page = 1'b0;

        ch_sel = 2'd3; ch_data = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333}; blank_lz = 1'b0;
        repeat (2) cyc();
        chk("oor_zero", hex_seg, {6{7'h40}});
        blank_lz = 1'b1;
        cyc();
        chk("oor_zero_lz", hex_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        ch_sel = 2'd2; set_ch(2, 32'h89AB_CDEF); blank_lz = 1'b0;
        repeat (3) cyc();
        page_btn = 1'b1;
        cyc();
        page_btn = 1'b0; freeze = 1'b1;
        repeat (2) cyc();
        chk("pre_rst_page", page_idx, 1'b1);
        chk("pre_rst_frozen", frozen, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_seg", hex_seg, {6{7'h7F}});
        chk("async_rst_page", page_idx, 1'b0);
        chk("async_rst_frozen", frozen, 1'b0);
        cyc();
        rst = 1'b0; freeze = 1'b0;
        repeat (2) cyc();
        chk("post_rst_seg", hex_seg, {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        chk("post_rst_page", page_idx, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
